// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read streamer.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned SKID_DEPTH     = 3;
  localparam int unsigned DEF_FIFO_WIDTH = 16;
  localparam int unsigned OCC_W          = 2;
  localparam int unsigned PTR_W          = 2;

  // Circular pointer advance over the SKID_DEPTH entries
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// 3-entry in-order buffer absorbing the FIFO read latency; head is the oldest word.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SKID_DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Head only moves on pop, so it stays stable while the consumer stalls
  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_streamer.sv
// Bursty FIFO drainer presenting a valid/ready stream.
// Optional sticky underflow flag: define FIFO_RD_UNDERFLOW_CHK_EN.
module fifo_rd_streamer
  import fifo_rd_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned TIMEOUT    = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_almostempty,
  input  logic                  fifo_underflow,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_W-1:0]      word_cnt,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned TCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t            state;
  state_t            state_nxt;
  logic [TCNT_W-1:0] tcnt;
  logic              timed_out;
  logic              inflight;
  logic [OCC_W-1:0]  occ;
  logic              push;
  logic              pop;

  assign timed_out = (32'(tcnt) >= TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = WAIT;
      WAIT:    if (!fifo_empty && (!fifo_almostempty || timed_out)) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty) state_nxt = WAIT;
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  // Idle timeout: zero outside WAIT, counts only while data is waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       tcnt <= '0;
    else if (state != WAIT)           tcnt <= '0;
    else if (!fifo_empty && !timed_out) tcnt <= tcnt + TCNT_W'(1);
  end

  // Credit check keeps buffered plus in-flight words within the buffer depth
  assign fifo_rd_en = enable && (state == DRAIN) && !fifo_empty &&
                      ((3'(occ) + 3'(inflight)) < 3'(SKID_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= fifo_rd_en;
  end

  assign push    = inflight && !fifo_underflow;
  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;
  assign busy    = inflight || (occ != '0);

  fifo_rd_skid #(
    .WIDTH (FIFO_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (fifo_data_out),
    .pop       (pop),
    .occ       (occ),
    .head      (m_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   word_cnt <= '0;
    else if (pop) word_cnt <= word_cnt + CNT_W'(1);
  end

`ifdef FIFO_RD_UNDERFLOW_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          err <= 1'b0;
    else if (inflight && fifo_underflow) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
